// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the round-robin / fixed-priority arbitrating mux:
// mode encodings, output-stage states and the select-width derivation.
package rr_arb_mux_pkg;

  localparam logic RR_MODE  = 1'b0;
  localparam logic FIX_MODE = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // A single channel still needs one bit of select so the port never vanishes.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb_grant.sv
// Combinational grant logic: one-hot grant plus encoded index, either scanning
// round-robin from the channel after LAST or taking the lowest set request.
module rr_arb_grant
  import rr_arb_mux_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [NUM_CH-1:0]    req,
  input  logic [SEL_WIDTH-1:0] last,
  input  logic                 mode,
  output logic [NUM_CH-1:0]    grant,
  output logic [SEL_WIDTH-1:0] idx
);

  logic found;
  int   ch;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    ch    = 0;
    if (mode == FIX_MODE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && req[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          idx      = SEL_WIDTH'(i);
        end
      end
    end else begin
      // Offsets 1..NUM_CH visit every channel once, ending on LAST itself.
      for (int k = 1; k <= NUM_CH; k++) begin
        ch = int'(last) + k;
        if (ch >= NUM_CH) ch = ch - NUM_CH;
        if (!found && req[ch]) begin
          found     = 1'b1;
          grant[ch] = 1'b1;
          idx       = SEL_WIDTH'(ch);
        end
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Registered N-channel arbitrating multiplexer with valid/ready on both sides.
// Note: OUT_READY reaches IN_READY combinationally through load_en.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         MODE,
  input  logic [NUM_CH-1:0]            IN_VALID,
  output logic [NUM_CH-1:0]            IN_READY,
  input  logic [NUM_CH*DATA_WIDTH-1:0] IN_DATA,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [DATA_WIDTH-1:0]        OUT_DATA,
  output logic [SEL_WIDTH-1:0]         OUT_SEL
);

  out_state_t             state, state_nxt;
  logic                   load_en;
  logic                   push;
  logic [NUM_CH-1:0]      grant;
  logic [SEL_WIDTH-1:0]   grant_idx;
  logic [SEL_WIDTH-1:0]   last;
  logic [DATA_WIDTH-1:0]  masked [NUM_CH];
  logic [DATA_WIDTH-1:0]  sel_data;

  assign OUT_VALID = (state == ST_FULL);
  assign load_en   = !OUT_VALID || OUT_READY;

  rr_arb_grant #(
    .NUM_CH    (NUM_CH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_grant (
    .req   (IN_VALID),
    .last  (last),
    .mode  (MODE),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign IN_READY = load_en ? grant : '0;
  assign push     = |IN_READY;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_mask
    assign masked[i] = IN_DATA[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}};
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_data = sel_data | masked[i];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_EMPTY;
    else      state <= state_nxt;
  end

  // The stage refills or drains only when the held word is gone or leaving.
  always_comb begin
    state_nxt = state;
    if (load_en) state_nxt = push ? ST_FULL : ST_EMPTY;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OUT_DATA <= '0;
      OUT_SEL  <= '0;
      last     <= SEL_WIDTH'(NUM_CH - 1);
    end else if (push) begin
      OUT_DATA <= sel_data;
      OUT_SEL  <= grant_idx;
      if (MODE == RR_MODE) last <= grant_idx;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed vector table, backpressure and
// reset sequences, randomized run against a reference model, and a 1-channel stream.
module tb_rr_arb_mux;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         mode = 1'b0;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;

  logic         in_valid1 = 1'b0;
  logic         in_ready1;
  logic [31:0]  in_data1 = '0;
  logic         out_valid1;
  logic         out_ready1 = 1'b0;
  logic [31:0]  out_data1;
  logic [0:0]   out_sel1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  rr_arb_mux #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_WIDTH(2)) dut (
    .CLK(CLK), .RST(RST), .MODE(mode),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_DATA(out_data), .OUT_SEL(out_sel)
  );

  rr_arb_mux #(.DATA_WIDTH(32), .NUM_CH(1), .SEL_WIDTH(1)) dut1 (
    .CLK(CLK), .RST(RST), .MODE(mode),
    .IN_VALID(in_valid1), .IN_READY(in_ready1), .IN_DATA(in_data1),
    .OUT_VALID(out_valid1), .OUT_READY(out_ready1),
    .OUT_DATA(out_data1), .OUT_SEL(out_sel1)
  );

  typedef struct {
    logic        md;
    logic [3:0]  v;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_valid;
    logic [1:0]  exp_sel;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[14];

  // Reference model of the 4-channel instance, kept as plain integers.
  bit          m_valid;
  logic [31:0] m_data;
  int          m_sel;
  int          m_last;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic md, input logic [3:0] v, input logic ordy);
    mode      = md;
    in_valid  = v;
    out_ready = ordy;
  endtask

  task automatic modelReset();
    m_valid = 0;
    m_data  = '0;
    m_sel   = 0;
    m_last  = 3;
  endtask

  task automatic modelGrant(input logic md, input logic [3:0] v, input logic ordy,
                            output logic [3:0] rdy, output int gi);
    int c;
    rdy = '0;
    gi  = -1;
    if ((!m_valid || ordy) && v != 4'b0) begin
      if (md) begin
        for (int i = 3; i >= 0; i--) if (v[i]) gi = i;
      end else begin
        for (int k = 4; k >= 1; k--) begin
          c = (m_last + k) % 4;
          if (v[c]) gi = c;
        end
      end
      rdy[gi] = 1'b1;
    end
  endtask

  task automatic modelUpdate(input logic md, input logic ordy, input int gi, input logic [31:0] word);
    if (!m_valid || ordy) begin
      if (gi >= 0) begin
        m_valid = 1;
        m_data  = word;
        m_sel   = gi;
        if (!md) m_last = gi;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  initial begin
    logic [3:0]  exp_rdy;
    int          gi;
    logic [31:0] word;
    logic [31:0] words1[8];
    int          sent, recv, cyc;
    bit          m1_valid;

    vecs[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    vecs[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
    vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
    vecs[8]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    vecs[9]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA2};
    vecs[10] = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    vecs[11] = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    vecs[12] = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    vecs[13] = '{1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};

    in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_sel", out_sel, 0);
    checkOutput("reset_n1_out_valid", out_valid1, 0);
    RST = 1'b1;

    // Directed table: fairness, wrap-around, drain, fixed priority, mode switch.
    for (int n = 0; n < 14; n++) begin
      applyStimulus(vecs[n].md, vecs[n].v, vecs[n].ordy);
      #3;
      checkOutput($sformatf("vec%0d_in_ready", n), in_ready, vecs[n].exp_rdy);
      @(posedge CLK);
      #1;
      checkOutput($sformatf("vec%0d_out_valid", n), out_valid, vecs[n].exp_valid);
      checkOutput($sformatf("vec%0d_out_sel", n), out_sel, vecs[n].exp_sel);
      checkOutput($sformatf("vec%0d_out_data", n), out_data, vecs[n].exp_data);
    end

    // Backpressure: hold ch2's word for five cycles, then pop-and-push.
    in_data[2*32 +: 32] = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 4'b0100, 1'b1);
    #3;
    checkOutput("bp_load_in_ready", in_ready, 4'b0100);
    @(posedge CLK);
    #1;
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0);
      #3;
      checkOutput("bp_in_ready", in_ready, 4'b0000);
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_out_sel", out_sel, 2);
      checkOutput("bp_out_data", out_data, 32'hDEAD_BEEF);
      @(posedge CLK);
      #1;
    end
    checkOutput("bp_hold_out_data", out_data, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    #3;
    checkOutput("bp_release_in_ready", in_ready, 4'b1000);
    @(posedge CLK);
    #1;
    checkOutput("bp_release_out_sel", out_sel, 3);
    checkOutput("bp_release_out_data", out_data, 32'hA3);
    checkOutput("bp_release_out_valid", out_valid, 1);

    // Asynchronous reset with a word held and no clock edge in between.
    applyStimulus(1'b0, 4'b0000, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", out_valid, 0);
    checkOutput("async_rst_out_data", out_data, 0);
    checkOutput("async_rst_out_sel", out_sel, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    in_data[2*32 +: 32] = 32'hA2;
    applyStimulus(1'b0, 4'b1111, 1'b1);
    #3;
    checkOutput("post_rst_in_ready", in_ready, 4'b0001);
    @(posedge CLK);
    #1;
    checkOutput("post_rst_out_sel", out_sel, 0);
    checkOutput("post_rst_out_data", out_data, 32'hA0);

    // Randomized run against the reference model, from a clean reset.
    RST = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    modelReset();
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 7) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
      #3;
      modelGrant(mode, in_valid, out_ready, exp_rdy, gi);
      checkOutput("rand_in_ready", in_ready, exp_rdy);
      checkOutput("rand_out_valid", out_valid, m_valid);
      checkOutput("rand_out_sel", out_sel, m_sel);
      checkOutput("rand_out_data", out_data, m_data);
      word = (gi >= 0) ? in_data[gi*32 +: 32] : 32'h0;
      @(posedge CLK);
      modelUpdate(mode, out_ready, gi, word);
      #1;
    end
    applyStimulus(1'b0, 4'b0000, 1'b0);

    // Single-channel instance as a one-entry pipeline register.
    for (int i = 0; i < 8; i++) words1[i] = $urandom;
    sent = 0;
    recv = 0;
    cyc  = 0;
    m1_valid = out_valid1;
    while (recv < 8 && cyc < 300) begin
      in_valid1  = (sent < 8) && ($urandom_range(0, 2) != 0);
      in_data1   = (sent < 8) ? words1[sent] : 32'h0;
      out_ready1 = ($urandom_range(0, 1) == 1);
      #3;
      checkOutput("n1_in_ready", in_ready1, (!m1_valid || out_ready1) && in_valid1);
      checkOutput("n1_out_valid", out_valid1, m1_valid);
      checkOutput("n1_out_sel", out_sel1, 0);
      if (out_valid1 && out_ready1) begin
        checkOutput($sformatf("n1_word%0d", recv), out_data1, words1[recv]);
        recv++;
      end
      @(posedge CLK);
      if (!m1_valid || out_ready1) begin
        m1_valid = in_valid1;
        if (in_valid1) sent++;
      end
      #1;
      cyc++;
    end
    checkOutput("n1_words_received", recv, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
